// File: rtl/param_code_lock.sv
// Parametrised keypad sequence lock: programmable code, attempt counting with timed
// lockout, and an idle timeout that abandons partial entries. All outputs registered.
module param_code_lock #(
   parameter int unsigned N_BUTTONS      = 4,
   parameter int unsigned CODE_LEN       = 4,
   parameter int unsigned MAX_TRIES      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 500
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_BUTTONS-1:0]           key,
   input  logic                           lock_req,
   input  logic                           prog_req,
   output logic [2:0]                     state,
   output logic                           unlocked,
   output logic                           locked_out,
   output logic                           fail,
   output logic [$clog2(CODE_LEN+1)-1:0]  entry_cnt,
   output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

   localparam int unsigned KW  = $clog2(N_BUTTONS);
   localparam int unsigned CW  = $clog2(CODE_LEN + 1);
   localparam int unsigned IW  = $clog2(CODE_LEN);
   localparam int unsigned TW  = $clog2(MAX_TRIES + 1);
   localparam int unsigned ITW = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned LTW = $clog2(LOCKOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      StLocked   = 3'd0,
      StEntry    = 3'd1,
      StUnlocked = 3'd2,
      StProgram  = 3'd3,
      StLockout  = 3'd4
   } state_e;

   state_e                       state_q, state_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic                         mism_q, mism_d;
   logic [TW-1:0]                tries_q, tries_d;
   logic [ITW-1:0]               idle_q, idle_d;
   logic [LTW-1:0]               lout_q, lout_d;
   logic [CODE_LEN-1:0][KW-1:0]  code_q, code_d;
   logic [CODE_LEN-1:0][KW-1:0]  shadow_q, shadow_d;
   logic                         fail_q, fail_d;
   logic                         unlocked_q, locked_out_q;

   logic          key_any, key_valid, key_mis, last_key, idle_done;
   logic [KW-1:0] key_idx;
   logic [IW-1:0] pos;

   always_comb begin
      key_idx = '0;
      for (int unsigned i = 0; i < N_BUTTONS; i++) begin
         if (key[i]) key_idx = KW'(i);
      end
      key_any   = |key;
      key_valid = key_any && ((key & (key - N_BUTTONS'(1))) == '0);
      pos       = IW'(cnt_q);
      key_mis   = !key_valid || (key_idx != code_q[pos]);
      last_key  = (cnt_q == CW'(CODE_LEN - 1));
      idle_done = (idle_q == ITW'(TIMEOUT_CYCLES - 1));
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mism_d   = mism_q;
      tries_d  = tries_q;
      idle_d   = idle_q;
      lout_d   = lout_q;
      code_d   = code_q;
      shadow_d = shadow_q;
      fail_d   = 1'b0;
      unique case (state_q)
         StLocked: begin
            idle_d = '0;
            if (key_any) begin
               state_d = StEntry;
               cnt_d   = CW'(1);
               mism_d  = key_mis;
            end
         end
         StEntry: begin
            if (key_any) begin
               idle_d = '0;
               if (last_key) begin
                  cnt_d = '0;
                  if (mism_q || key_mis) begin
                     fail_d  = 1'b1;
                     tries_d = tries_q - TW'(1);
                     if (tries_q == TW'(1)) begin
                        state_d = StLockout;
                        lout_d  = LTW'(LOCKOUT_CYCLES);
                     end else begin
                        state_d = StLocked;
                     end
                  end else begin
                     state_d = StUnlocked;
                     tries_d = TW'(MAX_TRIES);
                  end
               end else begin
                  cnt_d  = cnt_q + CW'(1);
                  mism_d = mism_q | key_mis;
               end
            end else if (idle_done) begin
               // Abandoned entry: silent return, no attempt charged.
               state_d = StLocked;
               cnt_d   = '0;
               idle_d  = '0;
            end else begin
               idle_d = idle_q + ITW'(1);
            end
         end
         StUnlocked: begin
            if (lock_req) begin
               state_d = StLocked;
            end else if (prog_req) begin
               state_d  = StProgram;
               cnt_d    = '0;
               idle_d   = '0;
               shadow_d = '0;
            end
         end
         StProgram: begin
            if (lock_req) begin
               state_d = StLocked;
               cnt_d   = '0;
            end else if (key_any) begin
               idle_d = '0;
               if (!key_valid) begin
                  state_d = StUnlocked;
                  cnt_d   = '0;
               end else begin
                  shadow_d[pos] = key_idx;
                  if (last_key) begin
                     code_d  = shadow_d;
                     state_d = StUnlocked;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end else if (idle_done) begin
               state_d = StUnlocked;
               cnt_d   = '0;
               idle_d  = '0;
            end else begin
               idle_d = idle_q + ITW'(1);
            end
         end
         StLockout: begin
            lout_d = lout_q - LTW'(1);
            if (lout_q <= LTW'(1)) begin
               state_d = StLocked;
               lout_d  = '0;
               tries_d = TW'(MAX_TRIES);
            end
         end
         default: state_d = StLocked;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StLocked;
         cnt_q        <= '0;
         mism_q       <= 1'b0;
         tries_q      <= TW'(MAX_TRIES);
         idle_q       <= '0;
         lout_q       <= '0;
         shadow_q     <= '0;
         fail_q       <= 1'b0;
         unlocked_q   <= 1'b0;
         locked_out_q <= 1'b0;
         for (int unsigned i = 0; i < CODE_LEN; i++) begin
            code_q[i] <= KW'(N_BUTTONS - 1 - (i % N_BUTTONS));
         end
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mism_q       <= mism_d;
         tries_q      <= tries_d;
         idle_q       <= idle_d;
         lout_q       <= lout_d;
         shadow_q     <= shadow_d;
         code_q       <= code_d;
         fail_q       <= fail_d;
         unlocked_q   <= (state_d == StUnlocked) || (state_d == StProgram);
         locked_out_q <= (state_d == StLockout);
      end
   end

   assign state      = state_q;
   assign unlocked   = unlocked_q;
   assign locked_out = locked_out_q;
   assign fail       = fail_q;
   assign entry_cnt  = cnt_q;
   assign tries_left = tries_q;

endmodule

// File: tb/tb_param_code_lock.sv
// Randomised bench for param_code_lock against a queue-based reference model,
// preceded by directed sequences for the main unlock/fail/lockout/program/reset paths.
module tb_param_code_lock;

   localparam int NB = 4;
   localparam int CL = 4;
   localparam int MT = 3;
   localparam int LC = 16;
   localparam int TC = 8;

   logic          clk;
   logic          rst;
   logic [NB-1:0] key;
   logic          lock_req;
   logic          prog_req;
   logic [2:0]    state;
   logic          unlocked;
   logic          locked_out;
   logic          fail;
   logic [2:0]    entry_cnt;
   logic [1:0]    tries_left;

   param_code_lock #(
      .N_BUTTONS      (NB),
      .CODE_LEN       (CL),
      .MAX_TRIES      (MT),
      .LOCKOUT_CYCLES (LC),
      .TIMEOUT_CYCLES (TC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key        (key),
      .lock_req   (lock_req),
      .prog_req   (prog_req),
      .state      (state),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .fail       (fail),
      .entry_cnt  (entry_cnt),
      .tries_left (tries_left)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: state as an integer, keys collected into queues and
   // judged as a whole sequence once complete.
   int m_state, m_tries, m_idle, m_left;
   bit m_fail;
   int m_code[CL];
   int m_entry[$];
   int m_prog[$];

   function automatic int enc(input logic [NB-1:0] k);
      if ($countones(k) != 1) return -1;
      for (int i = 0; i < NB; i++) if (k[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_tries = MT;
      m_idle  = 0;
      m_left  = 0;
      m_fail  = 0;
      for (int i = 0; i < CL; i++) m_code[i] = NB - 1 - (i % NB);
      m_entry.delete();
      m_prog.delete();
   endtask

   task automatic model_step(input logic r, input logic [NB-1:0] k, input logic lr,
                             input logic pr);
      bit ok;
      m_fail = 0;
      if (!r) begin
         model_reset();
         return;
      end
      case (m_state)
         0: if (k != 0) begin
               m_entry.delete();
               m_entry.push_back(enc(k));
               m_idle  = 0;
               m_state = 1;
            end
         1: if (k != 0) begin
               m_idle = 0;
               m_entry.push_back(enc(k));
               if (m_entry.size() == CL) begin
                  ok = 1;
                  for (int i = 0; i < CL; i++) if (m_entry[i] != m_code[i]) ok = 0;
                  m_entry.delete();
                  if (ok) begin
                     m_state = 2;
                     m_tries = MT;
                  end else begin
                     m_fail  = 1;
                     m_tries = m_tries - 1;
                     if (m_tries == 0) begin
                        m_state = 4;
                        m_left  = LC;
                     end else begin
                        m_state = 0;
                     end
                  end
               end
            end else begin
               m_idle++;
               if (m_idle == TC) begin
                  m_state = 0;
                  m_idle  = 0;
                  m_entry.delete();
               end
            end
         2: if (lr) m_state = 0;
            else if (pr) begin
               m_state = 3;
               m_idle  = 0;
               m_prog.delete();
            end
         3: if (lr) begin
               m_state = 0;
               m_prog.delete();
            end else if (k != 0) begin
               m_idle = 0;
               if (enc(k) < 0) begin
                  m_state = 2;
                  m_prog.delete();
               end else begin
                  m_prog.push_back(enc(k));
                  if (m_prog.size() == CL) begin
                     for (int i = 0; i < CL; i++) m_code[i] = m_prog[i];
                     m_prog.delete();
                     m_state = 2;
                  end
               end
            end else begin
               m_idle++;
               if (m_idle == TC) begin
                  m_state = 2;
                  m_idle  = 0;
                  m_prog.delete();
               end
            end
         4: begin
               m_left--;
               if (m_left == 0) begin
                  m_state = 0;
                  m_tries = MT;
               end
            end
         default: m_state = 0;
      endcase
   endtask

   task automatic tick(input logic r, input logic [NB-1:0] k, input logic lr, input logic pr);
      int exp_cnt;
      rst      = r;
      key      = k;
      lock_req = lr;
      prog_req = pr;
      @(posedge clk);
      model_step(r, k, lr, pr);
      #1;
      exp_cnt = (m_state == 1) ? m_entry.size() : (m_state == 3) ? m_prog.size() : 0;
      check("state", 32'(state), 32'(m_state));
      check("unlocked", 32'(unlocked), 32'((m_state == 2) || (m_state == 3)));
      check("locked_out", 32'(locked_out), 32'(m_state == 4));
      check("fail", 32'(fail), 32'(m_fail));
      check("entry_cnt", 32'(entry_cnt), 32'(exp_cnt));
      check("tries_left", 32'(tries_left), 32'(m_tries));
      rst      = 1'b1;
      key      = '0;
      lock_req = 1'b0;
      prog_req = 1'b0;
   endtask

   task automatic press(input logic [NB-1:0] k);
      tick(1'b1, k, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, '0, 1'b0, 1'b0);
   endtask

   task automatic seq(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [NB-1:0] c,
                      input logic [NB-1:0] d);
      press(a);
      press(b);
      press(c);
      press(d);
   endtask

   logic [NB-1:0] rk;
   logic          rlr, rpr, rrv;
   int            rsel, rpos, ra, rb;

   initial begin
      rst      = 1'b0;
      key      = '0;
      lock_req = 1'b0;
      prog_req = 1'b0;
      model_reset();
      tick(1'b0, '0, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0);
      check("rst_state", 32'(state), 0);
      check("rst_tries", 32'(tries_left), 3);

      // Default code 3,2,1,0
      seq(4'b1000, 4'b0100, 4'b0010, 4'b0001);
      check("unlock_default", 32'(state), 2);
      check("unlock_flag", 32'(unlocked), 1);
      tick(1'b1, '0, 1'b1, 1'b0);

      // Wrong entry: no early exit, one fail pulse
      press(4'b1000);
      press(4'b0010);
      press(4'b0010);
      check("no_early_exit", 32'(entry_cnt), 3);
      press(4'b0001);
      check("fail_pulse", 32'(fail), 1);
      check("fail_tries", 32'(tries_left), 2);
      idle(1);
      check("fail_once", 32'(fail), 0);

      // Two more fails -> lockout; correct code ignored inside it
      seq(4'b0001, 4'b0001, 4'b0001, 4'b0001);
      seq(4'b0001, 4'b0001, 4'b0001, 4'b0001);
      check("lockout_state", 32'(state), 4);
      check("lockout_flag", 32'(locked_out), 1);
      seq(4'b1000, 4'b0100, 4'b0010, 4'b0001);
      idle(11);
      check("lockout_hold", 32'(state), 4);
      idle(1);
      check("lockout_exit", 32'(state), 0);
      check("lockout_tries", 32'(tries_left), 3);
      seq(4'b1000, 4'b0100, 4'b0010, 4'b0001);
      check("unlock_after_out", 32'(state), 2);

      // Program new code 0,0,1,2
      tick(1'b1, '0, 1'b0, 1'b1);
      check("prog_enter", 32'(state), 3);
      press(4'b0001);
      press(4'b0001);
      press(4'b0010);
      check("prog_cnt", 32'(entry_cnt), 3);
      press(4'b0100);
      check("prog_done", 32'(state), 2);
      tick(1'b1, '0, 1'b1, 1'b0);
      seq(4'b1000, 4'b0100, 4'b0010, 4'b0001);
      check("old_code_fails", 32'(fail), 1);
      seq(4'b0001, 4'b0001, 4'b0010, 4'b0100);
      check("new_code_unlocks", 32'(state), 2);

      // Entry timeout, then invalid key aborts programming
      tick(1'b1, '0, 1'b1, 1'b0);
      press(4'b1000);
      idle(TC - 1);
      check("timeout_hold", 32'(state), 1);
      idle(1);
      check("timeout_state", 32'(state), 0);
      check("timeout_cnt", 32'(entry_cnt), 0);
      seq(4'b0001, 4'b0001, 4'b0010, 4'b0100);
      tick(1'b1, '0, 1'b0, 1'b1);
      press(4'b0011);
      check("prog_abort", 32'(state), 2);
      tick(1'b1, '0, 1'b1, 1'b0);
      seq(4'b0001, 4'b0001, 4'b0010, 4'b0100);
      check("code_kept", 32'(state), 2);

      // Reset mid-entry and mid-program restores the default code
      tick(1'b1, '0, 1'b1, 1'b0);
      press(4'b0001);
      press(4'b0001);
      press(4'b0010);
      tick(1'b0, '0, 1'b0, 1'b0);
      check("rst_entry_cnt", 32'(entry_cnt), 0);
      seq(4'b1000, 4'b0100, 4'b0010, 4'b0001);
      check("default_back", 32'(state), 2);
      tick(1'b1, '0, 1'b0, 1'b1);
      press(4'b0001);
      press(4'b0010);
      tick(1'b0, '0, 1'b0, 1'b0);
      check("rst_prog", 32'(state), 0);
      seq(4'b1000, 4'b0100, 4'b0010, 4'b0001);
      tick(1'b1, '0, 1'b1, 1'b1);
      check("lock_wins", 32'(state), 0);

      // Randomised traffic, biased towards the next correct key
      for (int n = 0; n < 3000; n++) begin
         rk   = '0;
         rlr  = 1'b0;
         rpr  = 1'b0;
         rrv  = 1'b1;
         rsel = $urandom_range(0, 99);
         if (rsel < 40) begin
            rk = '0;
         end else if (rsel < 65) begin
            rpos = (m_state == 1) ? m_entry.size() : 0;
            if (m_state == 3) rk = NB'(1) << $urandom_range(0, NB - 1);
            else rk = NB'(1) << m_code[rpos];
         end else if (rsel < 85) begin
            rk = NB'(1) << $urandom_range(0, NB - 1);
         end else if (rsel < 90) begin
            ra = $urandom_range(0, NB - 1);
            rb = (ra + 1 + $urandom_range(0, NB - 2)) % NB;
            rk = (NB'(1) << ra) | (NB'(1) << rb);
         end else if (rsel < 94) begin
            rlr = 1'b1;
         end else if (rsel < 98) begin
            rpr = 1'b1;
         end else if (rsel == 98) begin
            idle(TC + 1);
         end else begin
            rrv = ($urandom_range(0, 4) != 0);
         end
         tick(rrv, rk, rlr, rpr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/param_code_lock.md
Name: param_code_lock

Overview:
- Parametrised successor to the fixed 4-button sequence lock.
- Accepts single-cycle key pulses from the per-button debounce/rising-edge chain.
- Checks a CODE_LEN-entry code held in registers that can be reprogrammed while unlocked.
- Adds attempt counting with timed lockout and an entry timeout; registered status feeds the existing segment display and digit-switcher logic.

Parameters:
N_BUTTONS, 4, number of key inputs (>=2)
CODE_LEN, 4, entries per code (>=2)
MAX_TRIES, 3, consecutive failed attempts before lockout (>=1)
LOCKOUT_CYCLES, 1000, clk cycles spent in lockout (>=1)
TIMEOUT_CYCLES, 500, idle clk cycles that abandon a partial entry (>=2)
KW = $clog2(N_BUTTONS), derived, width of one stored code entry

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  active-low synchronous reset; sampled on posedge clk, low = reset
key  in  N_BUTTONS  one-cycle press pulses; exactly one bit high = valid key, >1 bit high = invalid key
lock_req  in  1  one-cycle request to relock from UNLOCKED
prog_req  in  1  one-cycle request to enter PROGRAM from UNLOCKED
state  out  3  LOCKED=0, ENTRY=1, UNLOCKED=2, PROGRAM=3, LOCKOUT=4
unlocked  out  1  high in UNLOCKED and PROGRAM
locked_out  out  1  high in LOCKOUT
fail  out  1  one-cycle pulse on each failed attempt
entry_cnt  out  $clog2(CODE_LEN+1)  keys accepted in current entry/program sequence
tries_left  out  $clog2(MAX_TRIES+1)  MAX_TRIES minus consecutive fails

Behaviour:
- Reset (rst low at posedge):
  - state=LOCKED, entry_cnt=0, fail=0, tries_left=MAX_TRIES, timers=0.
  - Code entry i resets to N_BUTTONS-1-(i mod N_BUTTONS); default 4x4 code = buttons 3,2,1,0.
  - Reset mid-entry, mid-program or mid-lockout discards all progress; a partial PROGRAM never alters the code.
- All outputs are registered; response appears the cycle after the input pulse. key==0 means no event.
- LOCKED: any nonzero key -> ENTRY, entry_cnt=1, mismatch flag = (key invalid or encoded key != code[0]).
- ENTRY:
  - Nonzero key: entry_cnt++, mismatch |= (invalid or key != code[entry_cnt]). No early rejection; the decision is made only after the CODE_LEN-th key.
  - On the CODE_LEN-th key, match -> UNLOCKED, tries_left=MAX_TRIES, entry_cnt=0.
  - On the CODE_LEN-th key, mismatch -> fail pulse, tries_left--, entry_cnt=0; if tries_left reaches 0 -> LOCKOUT with timer loaded to LOCKOUT_CYCLES, else LOCKED.
  - Idle timer counts cycles with key==0 and clears on any key. At TIMEOUT_CYCLES -> LOCKED, entry_cnt=0; not counted as a fail.
- UNLOCKED:
  - key ignored.
  - lock_req -> LOCKED.
  - prog_req -> PROGRAM, entry_cnt=0, shadow code cleared.
  - lock_req and prog_req together: lock_req wins.
- PROGRAM:
  - Valid key writes its encoded index into shadow[entry_cnt] and increments entry_cnt.
  - On the CODE_LEN-th key, shadow is copied to the code in the same cycle -> UNLOCKED.
  - Invalid key, lock_req, or idle timeout -> abort, code unchanged; lock_req -> LOCKED, the other two -> UNLOCKED.
- LOCKOUT:
  - key, lock_req and prog_req ignored.
  - Timer decrements each cycle; on reaching 0 -> LOCKED, tries_left=MAX_TRIES.
- fail is high for exactly one cycle per failed attempt and is never asserted by a timeout.

Test Plan:
- Defaults, after reset: keys 1000,0100,0010,0001 on separate cycles -> state 1,1,1,2, unlocked=1 the cycle after the 4th key, tries_left=3.
- Keys 1000,0010,0010,0001 -> no early exit, entry_cnt 1..3; after the 4th key state=0, fail=1 for one cycle, tries_left=2.
- Three wrong 4-key attempts with LOCKOUT_CYCLES=16 -> state=4, locked_out=1; the correct code during lockout is ignored; after 16 cycles state=0, tries_left=3, then the correct code unlocks.
- From UNLOCKED: prog_req, then keys 0001,0001,0010,0100 -> state 3 then 2; lock_req -> 0; old code now fails, new code unlocks.
- TIMEOUT_CYCLES=8: key 1000 then 8 idle cycles -> state=0, entry_cnt=0, fail never asserted; in PROGRAM, key 0011 -> abort to UNLOCKED, code unchanged.
- rst low during ENTRY after 3 correct keys, and again during PROGRAM -> state=0, entry_cnt=0, default code restored; lock_req and prog_req in the same cycle while UNLOCKED -> LOCKED.
